// File: rtl/multicycle_control_unit_pkg.sv
// Shared types for the multicycle control unit: ISA fields, ALU ops, FSM state and fault codes.
package multicycle_control_unit_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL  = 6'h03, OP_BEQ  = 6'h04,
        OP_BNE   = 6'h05, OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
        OP_SLTIU = 6'h0B, OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI = 6'h0E,
        OP_LUI   = 6'h0F, OP_LW    = 6'h23, OP_SW   = 6'h2B, OP_HALT = 6'h3F
    } opcode_t;

    typedef enum logic [5:0] {
        F_SLL  = 6'h00, F_SRL = 6'h02, F_JR  = 6'h08, F_ADD  = 6'h20,
        F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24,
        F_OR   = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27, F_SLT  = 6'h2A,
        F_SLTU = 6'h2B
    } funct_t;

    typedef enum logic [3:0] {
        ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
        ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
    } aluop_t;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} mc_state_t;

    typedef enum logic [1:0] {FLT_NONE, FLT_OVF, FLT_TIMEOUT, FLT_ILLEGAL} mc_fault_t;

    function automatic logic is_legal(opcode_t op, funct_t fn);
        logic w_ok;
        w_ok = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    F_SLL, F_SRL, F_JR, F_ADD, F_ADDU, F_SUB, F_SUBU,
                    F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: w_ok = 1'b1;
                    default: w_ok = 1'b0;
                endcase
            end
            OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW, OP_HALT: w_ok = 1'b1;
            default: w_ok = 1'b0;
        endcase
        return w_ok;
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Bundle between the IR/datapath and the multicycle control unit.
interface multicycle_control_unit_if;
    import multicycle_control_unit_pkg::*;

    opcode_t   opcode;
    funct_t    funct;
    logic      Zero, Overflow, ihit, dhit;
    logic      iREN, IR_EN, PC_EN;
    logic [1:0] PC_src;
    logic      Ext_src, LUI_src;
    logic [1:0] portb_src, RegDst;
    logic      RegWEN;
    aluop_t    ALU_op;
    logic      MemRead, MemWrite;
    logic [1:0] MemtoReg;
    logic      halt;
    mc_fault_t fault;
    mc_state_t state;

    modport master (
        input  opcode, funct, Zero, Overflow, ihit, dhit,
        output iREN, IR_EN, PC_EN, PC_src, Ext_src, LUI_src, portb_src, RegDst,
               RegWEN, ALU_op, MemRead, MemWrite, MemtoReg, halt, fault, state
    );

    modport slave (
        output opcode, funct, Zero, Overflow, ihit, dhit,
        input  iREN, IR_EN, PC_EN, PC_src, Ext_src, LUI_src, portb_src, RegDst,
               RegWEN, ALU_op, MemRead, MemWrite, MemtoReg, halt, fault, state
    );
endinterface

// File: rtl/mc_wait_timer.sv
// Memory-wait watchdog: counts consecutive wait cycles and flags when the limit is reached.
module mc_wait_timer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TMR_W       = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic CLK,
    input  logic nRST,
    input  logic count_en,
    input  logic clear,
    output logic expired
);
    localparam logic [TMR_W-1:0] LIMIT = TMR_W'(MEM_TIMEOUT);

    logic [TMR_W-1:0] r_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)         r_cnt <= '0;
        else if (clear)    r_cnt <= '0;
        else if (count_en) r_cnt <= r_cnt + TMR_W'(1);
    end

    assign expired = (r_cnt == LIMIT);
endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT with watchdog, overflow trap and fault code.
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TMR_W       = $clog2(MEM_TIMEOUT + 1),
    parameter bit OVF_TRAP    = 1'b1
) (
    input logic CLK,
    input logic nRST,
    multicycle_control_unit_if.master cuif
);
    mc_state_t r_state;
    mc_fault_t r_fault;
    logic w_count_en, w_clear, w_expired, w_ovf_op, w_ovf_trap;

    assign w_count_en = ((r_state == FETCH) && !cuif.ihit) || ((r_state == MEM) && !cuif.dhit);
    // Expiry forces HALT, so the counter restarts along with the state change.
    assign w_clear    = !w_count_en || w_expired;
    assign w_ovf_op   = (cuif.opcode == OP_ADDI) ||
                        ((cuif.opcode == OP_RTYPE) && ((cuif.funct == F_ADD) || (cuif.funct == F_SUB)));
    assign w_ovf_trap = OVF_TRAP && cuif.Overflow && w_ovf_op;

    mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TMR_W(TMR_W)) u_wait_timer (
        .CLK(CLK), .nRST(nRST), .count_en(w_count_en), .clear(w_clear), .expired(w_expired)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= FETCH;
            r_fault <= FLT_NONE;
        end else begin
            case (r_state)
                FETCH: begin
                    if (cuif.ihit) r_state <= DECODE;
                    else if (w_expired) begin r_state <= HALT; r_fault <= FLT_TIMEOUT; end
                end
                DECODE: begin
                    if (cuif.opcode == OP_HALT) begin r_state <= HALT; r_fault <= FLT_NONE; end
                    else if (!is_legal(cuif.opcode, cuif.funct)) begin r_state <= HALT; r_fault <= FLT_ILLEGAL; end
                    else r_state <= EXEC;
                end
                EXEC: begin
                    if (w_ovf_trap) begin r_state <= HALT; r_fault <= FLT_OVF; end
                    else begin
                        case (cuif.opcode)
                            OP_BEQ, OP_BNE, OP_J: r_state <= FETCH;
                            OP_RTYPE:             r_state <= (cuif.funct == F_JR) ? FETCH : WB;
                            OP_LW, OP_SW:         r_state <= MEM;
                            default:              r_state <= WB;
                        endcase
                    end
                end
                MEM: begin
                    if (cuif.dhit) r_state <= (cuif.opcode == OP_LW) ? WB : FETCH;
                    else if (w_expired) begin r_state <= HALT; r_fault <= FLT_TIMEOUT; end
                end
                WB:      r_state <= FETCH;
                HALT:    r_state <= HALT;
                default: r_state <= FETCH;
            endcase
        end
    end

    assign cuif.state = r_state;
    assign cuif.fault = r_fault;
    assign cuif.halt  = (r_state == HALT);

    always_comb begin
        cuif.iREN = 1'b0;      cuif.IR_EN = 1'b0;    cuif.PC_EN = 1'b0;
        cuif.PC_src = 2'b00;   cuif.Ext_src = 1'b0;  cuif.LUI_src = 1'b0;
        cuif.portb_src = 2'b00; cuif.RegDst = 2'b00; cuif.RegWEN = 1'b0;
        cuif.ALU_op = ALU_SLL; cuif.MemRead = 1'b0;  cuif.MemWrite = 1'b0;
        cuif.MemtoReg = 2'b00;
        case (r_state)
            FETCH: begin
                cuif.iREN  = 1'b1;
                cuif.IR_EN = cuif.ihit;
            end
            EXEC: begin
                case (cuif.opcode)
                    OP_RTYPE: begin
                        case (cuif.funct)
                            F_SLL:          begin cuif.ALU_op = ALU_SLL; cuif.portb_src = 2'b10; end
                            F_SRL:          begin cuif.ALU_op = ALU_SRL; cuif.portb_src = 2'b10; end
                            F_ADD, F_ADDU:  cuif.ALU_op = ALU_ADD;
                            F_SUB, F_SUBU:  cuif.ALU_op = ALU_SUB;
                            F_AND:          cuif.ALU_op = ALU_AND;
                            F_OR:           cuif.ALU_op = ALU_OR;
                            F_XOR:          cuif.ALU_op = ALU_XOR;
                            F_NOR:          cuif.ALU_op = ALU_NOR;
                            F_SLT:          cuif.ALU_op = ALU_SLT;
                            F_SLTU:         cuif.ALU_op = ALU_SLTU;
                            F_JR:           begin cuif.PC_EN = 1'b1; cuif.PC_src = 2'b11; end
                            default:        cuif.ALU_op = ALU_SLL;
                        endcase
                    end
                    OP_BEQ: begin
                        cuif.ALU_op = ALU_SUB; cuif.Ext_src = 1'b1; cuif.PC_EN = 1'b1;
                        cuif.PC_src = cuif.Zero ? 2'b01 : 2'b00;
                    end
                    OP_BNE: begin
                        cuif.ALU_op = ALU_SUB; cuif.Ext_src = 1'b1; cuif.PC_EN = 1'b1;
                        cuif.PC_src = cuif.Zero ? 2'b00 : 2'b01;
                    end
                    OP_J:                 begin cuif.PC_EN = 1'b1; cuif.PC_src = 2'b10; end
                    OP_ADDI, OP_ADDIU,
                    OP_LW, OP_SW:         begin cuif.ALU_op = ALU_ADD;  cuif.portb_src = 2'b01; cuif.Ext_src = 1'b1; end
                    OP_SLTI:              begin cuif.ALU_op = ALU_SLT;  cuif.portb_src = 2'b01; cuif.Ext_src = 1'b1; end
                    OP_SLTIU:             begin cuif.ALU_op = ALU_SLTU; cuif.portb_src = 2'b01; cuif.Ext_src = 1'b1; end
                    OP_ANDI:              begin cuif.ALU_op = ALU_AND;  cuif.portb_src = 2'b01; end
                    OP_ORI:               begin cuif.ALU_op = ALU_OR;   cuif.portb_src = 2'b01; end
                    OP_XORI:              begin cuif.ALU_op = ALU_XOR;  cuif.portb_src = 2'b01; end
                    OP_LUI:               begin cuif.ALU_op = ALU_OR;   cuif.portb_src = 2'b01; cuif.LUI_src = 1'b1; end
                    default:              cuif.ALU_op = ALU_SLL;
                endcase
            end
            MEM: begin
                cuif.ALU_op   = ALU_ADD;
                cuif.MemRead  = (cuif.opcode == OP_LW);
                cuif.MemWrite = (cuif.opcode == OP_SW);
                cuif.PC_EN    = (cuif.opcode == OP_SW) && cuif.dhit;
            end
            WB: begin
                cuif.RegWEN = 1'b1;
                cuif.PC_EN  = 1'b1;
                case (cuif.opcode)
                    OP_RTYPE: cuif.RegDst = 2'b00;
                    OP_LW:    begin cuif.RegDst = 2'b01; cuif.MemtoReg = 2'b01; end
                    OP_JAL:   begin cuif.RegDst = 2'b10; cuif.MemtoReg = 2'b10; cuif.PC_src = 2'b10; end
                    default:  cuif.RegDst = 2'b01;
                endcase
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench: two control units (overflow trap on/off, 4-cycle watchdog) against an instruction-level model.
module tb_multicycle_control_unit;
    import multicycle_control_unit_pkg::*;

    localparam int TMO = 4;
    localparam int K_RT = 0, K_JR = 1, K_IT = 2, K_LW = 3, K_SW = 4, K_BEQ = 5,
                   K_BNE = 6, K_J = 7, K_JAL = 8, K_HALT = 9, K_ILL = 10;
    localparam logic [25:0] RESET_VEC = {1'b1, 25'b0};

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         kind;
        aluop_t     alu;
        logic [1:0] portb;
        logic       ext;
        logic       lui;
        bit         ovf;
    } instr_t;

    logic CLK, nRST;
    opcode_t t_op;
    funct_t  t_fn;
    logic t_zero, t_ovf, t_ihit, t_dhit;

    multicycle_control_unit_if ifa ();
    multicycle_control_unit_if ifb ();

    assign ifa.opcode = t_op;  assign ifb.opcode = t_op;
    assign ifa.funct = t_fn;   assign ifb.funct = t_fn;
    assign ifa.Zero = t_zero;  assign ifb.Zero = t_zero;
    assign ifa.Overflow = t_ovf; assign ifb.Overflow = t_ovf;
    assign ifa.ihit = t_ihit;  assign ifb.ihit = t_ihit;
    assign ifa.dhit = t_dhit;  assign ifb.dhit = t_dhit;

    multicycle_control_unit #(.MEM_TIMEOUT(TMO), .OVF_TRAP(1'b1)) dut_a (.CLK(CLK), .nRST(nRST), .cuif(ifa));
    multicycle_control_unit #(.MEM_TIMEOUT(TMO), .OVF_TRAP(1'b0)) dut_b (.CLK(CLK), .nRST(nRST), .cuif(ifb));

    logic [25:0] got_a, got_b;
    assign got_a = {ifa.iREN, ifa.IR_EN, ifa.PC_EN, ifa.PC_src, ifa.Ext_src, ifa.LUI_src, ifa.portb_src,
                    ifa.RegDst, ifa.RegWEN, ifa.ALU_op, ifa.MemRead, ifa.MemWrite, ifa.MemtoReg,
                    ifa.halt, ifa.fault, ifa.state};
    assign got_b = {ifb.iREN, ifb.IR_EN, ifb.PC_EN, ifb.PC_src, ifb.Ext_src, ifb.LUI_src, ifb.portb_src,
                    ifb.RegDst, ifb.RegWEN, ifb.ALU_op, ifb.MemRead, ifb.MemWrite, ifb.MemtoReg,
                    ifb.halt, ifb.fault, ifb.state};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    instr_t tbl[$];
    instr_t cur;
    int m_ph[2], m_flt[2], m_miss[2];
    bit m_trap[2] = '{1'b1, 1'b0};
    int n_chk = 0, n_err = 0;
    int p_hit = 100, h_cnt = 0, h_lim = 2;
    bit need_new = 1'b1;

    task automatic check(input string tag, input logic [25:0] got, input logic [25:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void add(logic [5:0] op, logic [5:0] fn, int k, aluop_t a,
                                logic [1:0] pb, logic ex, logic lu, bit ov);
        instr_t e;
        e.op = op; e.fn = fn; e.kind = k; e.alu = a; e.portb = pb; e.ext = ex; e.lui = lu; e.ovf = ov;
        tbl.push_back(e);
    endfunction

    function automatic int find(logic [5:0] op, logic [5:0] fn);
        for (int i = 0; i < tbl.size(); i++)
            if (tbl[i].op == op && (op != 6'd0 || tbl[i].fn == fn)) return i;
        return -1;
    endfunction

    function automatic void pick();
        int r, idx;
        logic [5:0] op, fn;
        r  = int'($urandom_range(0, 99));
        op = 6'($urandom_range(0, 63));
        fn = 6'($urandom_range(0, 63));
        cur = '{op: op, fn: fn, kind: K_ILL, alu: ALU_SLL, portb: 2'b00, ext: 1'b0, lui: 1'b0, ovf: 1'b0};
        if (r < 3) begin
            cur.op = OP_HALT; cur.kind = K_HALT;
        end else if (r < 13) begin
            idx = find(op, fn);
            if (idx >= 0) begin cur = tbl[idx]; cur.fn = fn; end
            else if (op == OP_HALT) cur.kind = K_HALT;
        end else begin
            cur = tbl[$urandom_range(0, tbl.size() - 1)];
            if (cur.op != 6'd0) cur.fn = fn;
        end
        r = int'($urandom_range(0, 9));
        p_hit = (r < 6) ? 100 : (r < 8) ? 50 : 15;
        t_op = opcode_t'(cur.op);
        t_fn = funct_t'(cur.fn);
    endfunction

    function automatic logic [25:0] exp_vec(int d);
        logic iren, irl, pcen, ext, lui, rwen, mrd, mwr, hlt;
        logic [1:0] pcs, pb, rd, m2r;
        logic [3:0] alu;
        {iren, irl, pcen, ext, lui, rwen, mrd, mwr, hlt} = '0;
        pcs = '0; pb = '0; rd = '0; m2r = '0; alu = '0;
        case (m_ph[d])
            0: begin iren = 1'b1; irl = t_ihit; end
            2: begin
                alu = cur.alu; pb = cur.portb; ext = cur.ext; lui = cur.lui;
                case (cur.kind)
                    K_BEQ: begin pcen = 1'b1; pcs = t_zero ? 2'd1 : 2'd0; end
                    K_BNE: begin pcen = 1'b1; pcs = t_zero ? 2'd0 : 2'd1; end
                    K_J:   begin pcen = 1'b1; pcs = 2'd2; end
                    K_JR:  begin pcen = 1'b1; pcs = 2'd3; end
                    default: ;
                endcase
            end
            3: begin
                alu = ALU_ADD;
                mrd = (cur.kind == K_LW);
                mwr = (cur.kind == K_SW);
                pcen = (cur.kind == K_SW) && t_dhit;
            end
            4: begin
                rwen = 1'b1; pcen = 1'b1;
                case (cur.kind)
                    K_RT:    rd = 2'd0;
                    K_LW:    begin rd = 2'd1; m2r = 2'd1; end
                    K_JAL:   begin rd = 2'd2; m2r = 2'd2; pcs = 2'd2; end
                    default: rd = 2'd1;
                endcase
            end
            5: hlt = 1'b1;
            default: ;
        endcase
        return {iren, irl, pcen, pcs, ext, lui, pb, rd, rwen, alu, mrd, mwr, m2r, hlt,
                2'(m_flt[d]), 3'(m_ph[d])};
    endfunction

    function automatic void advance(int d);
        int ph, nx;
        ph = m_ph[d];
        nx = ph;
        case (ph)
            0: if (t_ihit) nx = 1;
               else begin
                   m_miss[d]++;
                   if (m_miss[d] > TMO) begin nx = 5; m_flt[d] = 2; end
               end
            1: if (cur.kind == K_HALT) begin nx = 5; m_flt[d] = 0; end
               else if (cur.kind == K_ILL) begin nx = 5; m_flt[d] = 3; end
               else nx = 2;
            2: if (m_trap[d] && t_ovf && cur.ovf) begin nx = 5; m_flt[d] = 1; end
               else if (cur.kind inside {K_BEQ, K_BNE, K_J, K_JR}) nx = 0;
               else if (cur.kind inside {K_LW, K_SW}) nx = 3;
               else nx = 4;
            3: if (t_dhit) nx = (cur.kind == K_LW) ? 4 : 0;
               else begin
                   m_miss[d]++;
                   if (m_miss[d] > TMO) begin nx = 5; m_flt[d] = 2; end
               end
            4: nx = 0;
            default: nx = 5;
        endcase
        if (nx != ph) m_miss[d] = 0;
        if (ph == 0 && nx == 1) need_new = 1'b1;
        m_ph[d] = nx;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin m_ph[d] = 0; m_flt[d] = 0; m_miss[d] = 0; end
        need_new = 1'b1;
        h_cnt = 0;
        h_lim = int'($urandom_range(1, 5));
    endfunction

    // Async reset in mid-cycle; hits held low so the reset outputs are a fixed vector.
    task automatic do_reset(input int c);
        t_ihit = 1'b0; t_dhit = 1'b0;
        #0 nRST = 1'b0;
        #1;
        check($sformatf("rstA cyc%0d", c), got_a, RESET_VEC);
        check($sformatf("rstB cyc%0d", c), got_b, RESET_VEC);
        #1 nRST = 1'b1;
        model_reset();
    endtask

    initial begin
        add(OP_RTYPE, F_SLL,  K_RT, ALU_SLL,  2'd2, 1'b0, 1'b0, 1'b0);
        add(OP_RTYPE, F_SRL,  K_RT, ALU_SRL,  2'd2, 1'b0, 1'b0, 1'b0);
        add(OP_RTYPE, F_ADD,  K_RT, ALU_ADD,  2'd0, 1'b0, 1'b0, 1'b1);
        add(OP_RTYPE, F_ADDU, K_RT, ALU_ADD,  2'd0, 1'b0, 1'b0, 1'b0);
        add(OP_RTYPE, F_SUB,  K_RT, ALU_SUB,  2'd0, 1'b0, 1'b0, 1'b1);
        add(OP_RTYPE, F_SUBU, K_RT, ALU_SUB,  2'd0, 1'b0, 1'b0, 1'b0);
        add(OP_RTYPE, F_AND,  K_RT, ALU_AND,  2'd0, 1'b0, 1'b0, 1'b0);
        add(OP_RTYPE, F_OR,   K_RT, ALU_OR,   2'd0, 1'b0, 1'b0, 1'b0);
        add(OP_RTYPE, F_XOR,  K_RT, ALU_XOR,  2'd0, 1'b0, 1'b0, 1'b0);
        add(OP_RTYPE, F_NOR,  K_RT, ALU_NOR,  2'd0, 1'b0, 1'b0, 1'b0);
        add(OP_RTYPE, F_SLT,  K_RT, ALU_SLT,  2'd0, 1'b0, 1'b0, 1'b0);
        add(OP_RTYPE, F_SLTU, K_RT, ALU_SLTU, 2'd0, 1'b0, 1'b0, 1'b0);
        add(OP_RTYPE, F_JR,   K_JR, ALU_SLL,  2'd0, 1'b0, 1'b0, 1'b0);
        add(OP_J,     6'd0,   K_J,   ALU_SLL,  2'd0, 1'b0, 1'b0, 1'b0);
        add(OP_JAL,   6'd0,   K_JAL, ALU_SLL,  2'd0, 1'b0, 1'b0, 1'b0);
        add(OP_BEQ,   6'd0,   K_BEQ, ALU_SUB,  2'd0, 1'b1, 1'b0, 1'b0);
        add(OP_BNE,   6'd0,   K_BNE, ALU_SUB,  2'd0, 1'b1, 1'b0, 1'b0);
        add(OP_ADDI,  6'd0,   K_IT,  ALU_ADD,  2'd1, 1'b1, 1'b0, 1'b1);
        add(OP_ADDIU, 6'd0,   K_IT,  ALU_ADD,  2'd1, 1'b1, 1'b0, 1'b0);
        add(OP_SLTI,  6'd0,   K_IT,  ALU_SLT,  2'd1, 1'b1, 1'b0, 1'b0);
        add(OP_SLTIU, 6'd0,   K_IT,  ALU_SLTU, 2'd1, 1'b1, 1'b0, 1'b0);
        add(OP_ANDI,  6'd0,   K_IT,  ALU_AND,  2'd1, 1'b0, 1'b0, 1'b0);
        add(OP_ORI,   6'd0,   K_IT,  ALU_OR,   2'd1, 1'b0, 1'b0, 1'b0);
        add(OP_XORI,  6'd0,   K_IT,  ALU_XOR,  2'd1, 1'b0, 1'b0, 1'b0);
        add(OP_LUI,   6'd0,   K_IT,  ALU_OR,   2'd1, 1'b0, 1'b1, 1'b0);
        add(OP_LW,    6'd0,   K_LW,  ALU_ADD,  2'd1, 1'b1, 1'b0, 1'b0);
        add(OP_SW,    6'd0,   K_SW,  ALU_ADD,  2'd1, 1'b1, 1'b0, 1'b0);

        nRST = 1'b0;
        t_op = OP_RTYPE; t_fn = F_ADDU;
        t_zero = 1'b0; t_ovf = 1'b0; t_ihit = 1'b0; t_dhit = 1'b0;
        #3;
        check("initA", got_a, RESET_VEC);
        check("initB", got_b, RESET_VEC);
        nRST = 1'b1;
        model_reset();
        advance(0); advance(1);
        @(posedge CLK); #1;

        for (int c = 0; c < 4000; c++) begin
            if (need_new && (m_ph[0] inside {0, 5}) && (m_ph[1] inside {0, 5})) begin
                pick();
                need_new = 1'b0;
            end
            t_ihit = (int'($urandom_range(0, 99)) < p_hit);
            t_dhit = (int'($urandom_range(0, 99)) < p_hit);
            t_zero = 1'($urandom_range(0, 1));
            t_ovf  = ($urandom_range(0, 3) == 0);
            #2;
            check($sformatf("dutA cyc%0d", c), got_a, exp_vec(0));
            check($sformatf("dutB cyc%0d", c), got_b, exp_vec(1));
            if (m_ph[0] == 5 || m_ph[1] == 5) h_cnt++;
            if (h_cnt > h_lim || $urandom_range(0, 199) == 0) do_reset(c);
            advance(0);
            advance(1);
            @(posedge CLK); #1;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
